// File: rtl/ram_dp_sync_read.sv
// Dual-port RAM with registered read, write-first bypass and a zeroing sweep after reset or clear.
// Optional even-parity protection per word is enabled by defining RAM_PARITY_EN.
module ram_dp_sync_read #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  clear,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  wr_par_flip,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  parity_err,
   output logic                  init_done
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int CNT_W = ADDR_WIDTH + 1;

   typedef enum logic {SWEEP, READY} state_t;

   state_t                state;
   logic [CNT_W-1:0]      cnt;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  user_wr;
   logic                  user_rd;
   logic                  bypass;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_din;
   logic [DATA_WIDTH-1:0] rd_word;

   // Port traffic is only honoured while READY and not being cleared.
   assign user_wr = (state == READY) && !clear && wr_en;
   assign user_rd = (state == READY) && !clear && rd_en;
   assign bypass  = user_wr && (wr_addr == rd_addr);
   assign rd_word = bypass ? wr_data : mem[rd_addr];

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      mem_we   = 1'b0;
      mem_addr = wr_addr;
      mem_din  = wr_data;
      if (reset_n) begin
         if (state == SWEEP) begin
            mem_we   = 1'b1;
            mem_addr = cnt[ADDR_WIDTH-1:0];
            mem_din  = '0;
         end else if (user_wr) begin
            mem_we = 1'b1;
         end
      end
   end

`ifdef RAM_PARITY_EN
   logic par_mem [DEPTH];
   logic par_din;
   logic rd_par;

   assign par_din = (state == SWEEP) ? 1'b0 : (^wr_data) ^ wr_par_flip;
   assign rd_par  = bypass ? ((^wr_data) ^ wr_par_flip) : par_mem[rd_addr];
`else
   logic unused_par_flip;
   assign unused_par_flip = wr_par_flip;
`endif

   // NOTE: the array has no reset; the sweep zeroes it so it can map onto block RAM.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_addr] <= mem_din;
`ifdef RAM_PARITY_EN
         par_mem[mem_addr] <= par_din;
`endif
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= SWEEP;
         cnt        <= '0;
         init_done  <= 1'b0;
         rd_data    <= '0;
         rd_valid   <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         case (state)
            SWEEP: begin
               if (clear) begin
                  cnt <= '0;
               end else if (cnt == CNT_W'(DEPTH - 1)) begin
                  state     <= READY;
                  init_done <= 1'b1;
                  cnt       <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            READY: begin
               if (clear) begin
                  state     <= SWEEP;
                  cnt       <= '0;
                  init_done <= 1'b0;
               end
            end
            default: begin
               state     <= SWEEP;
               cnt       <= '0;
               init_done <= 1'b0;
            end
         endcase

         rd_valid <= user_rd;
         if (user_rd) begin
            rd_data <= rd_word;
         end
`ifdef RAM_PARITY_EN
         parity_err <= user_rd && (rd_par != ^rd_word);
`else
         parity_err <= 1'b0;
`endif
      end
   end

endmodule

// File: tb/tb_ram_dp_sync_read.sv
// Scoreboard bench for ram_dp_sync_read: reads push expectations, a negedge monitor pops and compares.
module tb_ram_dp_sync_read;

   logic       clk;
   logic       reset_n;
   logic       clear;
   logic       wr_en;
   logic [3:0] wr_addr;
   logic [7:0] wr_data;
   logic       wr_par_flip;
   logic       rd_en;
   logic [3:0] rd_addr;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       parity_err;
   logic       init_done;

`ifdef RAM_PARITY_EN
   localparam logic PERR = 1'b1;
`else
   localparam logic PERR = 1'b0;
`endif

   typedef struct {
      logic [7:0] data;
      logic       perr;
      int         issue;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   ram_dp_sync_read #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .clear       (clear),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .wr_par_flip (wr_par_flip),
      .rd_en       (rd_en),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .rd_valid    (rd_valid),
      .parity_err  (parity_err),
      .init_done   (init_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every valid read must match the oldest expectation, one cycle after issue.
   always @(negedge clk) begin
      if (rd_valid === 1'b1) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL stray_rd_valid: got rd_valid=1 expected 0 (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("rd_data", 32'(rd_data), 32'(e.data));
            check("parity_err", 32'(parity_err), 32'(e.perr));
            check("rd_latency", 32'(cyc), 32'(e.issue + 1));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d, input logic flip);
      wr_en = 1'b1; wr_addr = a; wr_data = d; wr_par_flip = flip;
      step();
      wr_en = 1'b0; wr_par_flip = 1'b0;
   endtask

   task automatic rd(input logic [3:0] a, input logic [7:0] d, input logic perr);
      rd_en = 1'b1; rd_addr = a;
      q.push_back('{data: d, perr: perr, issue: cyc});
      step();
      rd_en = 1'b0;
   endtask

   task automatic wait_init(input string name, input int exp);
      int n = 0;
      do begin
         step();
         n++;
      end while (init_done !== 1'b1 && n < 200);
      check(name, 32'(n), 32'(exp));
   endtask

   initial begin
      reset_n = 1'b0; clear = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      wr_par_flip = 1'b0; rd_en = 1'b0; rd_addr = '0;
      repeat (3) step();
      check("rst_rd_valid", 32'(rd_valid), 32'd0);
      check("rst_rd_data", 32'(rd_data), 32'd0);
      check("rst_parity_err", 32'(parity_err), 32'd0);
      check("rst_init_done", 32'(init_done), 32'd0);

      reset_n = 1'b1;
      wait_init("init_after_reset", 16);
      for (int i = 0; i < 16; i++) rd(4'(i), 8'h00, 1'b0);

      wr(4'd3, 8'hA5, 1'b0);
      rd(4'd3, 8'hA5, 1'b0);

      // Same-cycle write/read: bypass on same address, old contents elsewhere.
      wr_en = 1'b1; wr_addr = 4'd7; wr_data = 8'h3C;
      rd(4'd7, 8'h3C, 1'b0);
      wr_addr = 4'd7; wr_data = 8'h99;
      rd(4'd8, 8'h00, 1'b0);
      wr_en = 1'b0;
      rd(4'd7, 8'h99, 1'b0);

      // Clear wipes memory; traffic during the sweep is ignored.
      wr(4'd15, 8'hFF, 1'b0);
      rd(4'd15, 8'hFF, 1'b0);
      clear = 1'b1;
      step();
      clear = 1'b0;
      check("init_drop_on_clear", 32'(init_done), 32'd0);
      wr_en = 1'b1; wr_addr = 4'd15; wr_data = 8'h77; rd_en = 1'b1; rd_addr = 4'd15;
      wait_init("init_after_clear", 16);
      wr_en = 1'b0; rd_en = 1'b0;
      rd(4'd15, 8'h00, 1'b0);

      // Reset in the middle of a sweep.
      wr(4'd1, 8'h5A, 1'b0);
      rd(4'd1, 8'h5A, 1'b0);
      clear = 1'b1;
      step();
      clear = 1'b0;
      repeat (4) step();
      reset_n = 1'b0;
      step();
      check("mid_rst_rd_data", 32'(rd_data), 32'd0);
      check("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
      check("mid_rst_init_done", 32'(init_done), 32'd0);
      reset_n = 1'b1;
      wait_init("init_after_mid_reset", 16);
      rd(4'd1, 8'h00, 1'b0);

      // Parity error injection through memory and through the bypass path.
      wr(4'd2, 8'h12, 1'b1);
      rd(4'd2, 8'h12, PERR);
      wr_en = 1'b1; wr_addr = 4'd4; wr_data = 8'h34; wr_par_flip = 1'b1;
      rd(4'd4, 8'h34, PERR);
      wr_en = 1'b0; wr_par_flip = 1'b0;
      rd(4'd4, 8'h34, PERR);
      wr(4'd5, 8'h07, 1'b0);
      rd(4'd5, 8'h07, 1'b0);

      repeat (3) step();
      check("queue_drained", 32'(q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
